// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/debug-read sequencer.
//   state_e   : sequencer states
//   MSEL_*    : data-memory port mux select encoding
//   is_rd_state() : true while the debug reader owns the memory port
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StRun,
    StHalt,
    StStep,
    StRdSetup,
    StRdCap
  } state_e;

  localparam logic MSEL_CPU = 1'b0;
  localparam logic MSEL_DBG = 1'b1;

  function automatic logic is_rd_state(state_e s);
    return (s == StRdSetup) || (s == StRdCap);
  endfunction

endpackage

// File: rtl/ce_prescaler.sv
// CPU enable prescaler: counts 0..ClkDiv-1 and wraps.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (count to 0)
//   clr_i  : clear count to 0 (wins over adv_i)
//   adv_i  : advance count by one, wrapping after ClkDiv-1; count holds otherwise
//   tc_o   : count is at its terminal value ClkDiv-1
module ce_prescaler #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic adv_i,
  output logic tc_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(ClkDiv - 1);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr_i) begin
      div_cnt_d = '0;
    end else if (adv_i) begin
      div_cnt_d = (div_cnt_q == TcVal) ? '0 : div_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tc_o = (div_cnt_q == TcVal);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/debug-read sequencer for the CPU. Produces a single-clock CPU
// enable (free-run at 1/CLK_DIV, halt, single step) and, between enables,
// lends the data-memory read port to the switch-driven debug reader.
//   clk, rst        : clock, synchronous active-high reset
//   run_sw          : 1 = free-run, 0 = halt (level)
//   step_pulse      : one-cycle request for a single step while halted
//   dbg_rd_req      : debug read request, rising-edge sensitive
//   dbg_rd_addr     : debug word address, sampled when the read is accepted
//   mem_rdata       : asynchronous data-memory read data
//   cpu_ce          : CPU clock enable
//   mem_sel         : memory port mux select (MSEL_CPU / MSEL_DBG)
//   mem_addr_dbg    : debug address to the memory mux
//   dbg_rd_data     : captured read word, valid with dbg_rd_valid
//   dbg_rd_valid    : one-cycle strobe when dbg_rd_data is updated
//   halted          : 1 in HALT and STEP, held across a debug read
//   ce_ticks        : count of cpu_ce pulses, wrapping
module cpu_run_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TICK_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_sw,
  input  logic              step_pulse,
  input  logic              dbg_rd_req,
  input  logic [ADDR_W-1:0] dbg_rd_addr,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_ce,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr_dbg,
  output logic [31:0]       dbg_rd_data,
  output logic              dbg_rd_valid,
  output logic              halted,
  output logic [TICK_W-1:0] ce_ticks
);

  import cpu_ctrl_pkg::*;

  state_e state_q, state_d;
  state_e saved_q, saved_d;

  logic              req_prev_q;
  logic              armed_q, armed_d;
  logic              edge_det;
  logic              accept;
  logic              div_clr, div_adv, div_tc;

  logic              cpu_ce_q, cpu_ce_d;
  logic              mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [TICK_W-1:0] ticks_q, ticks_d;

  ce_prescaler #(
    .ClkDiv (CLK_DIV)
  ) u_ce_prescaler (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (div_clr),
    .adv_i (div_adv),
    .tc_o  (div_tc)
  );

  assign edge_det = dbg_rd_req & ~req_prev_q;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    accept  = 1'b0;
    div_clr = 1'b0;
    div_adv = 1'b0;

    unique case (state_q)
      StRun: begin
        // A read may take any cycle that would not issue an enable. The
        // accepting cycle still counts, so the stall is exactly the two
        // read cycles.
        if (armed_q && (!div_tc || !run_sw)) begin
          accept  = 1'b1;
          saved_d = StRun;
          state_d = StRdSetup;
          div_adv = run_sw & ~div_tc;
        end else if (!run_sw) begin
          state_d = StHalt;
        end else begin
          div_adv = 1'b1;
        end
      end
      StHalt: begin
        if (armed_q) begin
          accept  = 1'b1;
          saved_d = StHalt;
          state_d = StRdSetup;
        end else if (edge_det) begin
          // Request arriving now outranks step/run; step is dropped.
          state_d = StHalt;
        end else if (step_pulse) begin
          state_d = StStep;
        end else if (run_sw) begin
          state_d = StRun;
          div_clr = 1'b1;
        end
      end
      StStep:    state_d = StHalt;
      StRdSetup: state_d = StRdCap;
      StRdCap:   state_d = saved_q;
      default:   state_d = StHalt;
    endcase
  end

  // Registered outputs decoded from the next state.
  always_comb begin
    armed_d   = (armed_q & ~accept) | edge_det;
    cpu_ce_d  = (state_d == StStep) ||
                ((state_q == StRun) && (state_d == StRun) && div_tc);
    mem_sel_d = is_rd_state(state_d) ? MSEL_DBG : MSEL_CPU;
    addr_d    = accept ? dbg_rd_addr : addr_q;
    data_d    = (state_q == StRdSetup) ? mem_rdata : data_q;
    valid_d   = (state_d == StRdCap);
    ticks_d   = ticks_q + TICK_W'(cpu_ce_q);
    case (state_d)
      StHalt, StStep: halted_d = 1'b1;
      StRun:          halted_d = 1'b0;
      default:        halted_d = halted_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHalt;
      saved_q    <= StHalt;
      // Track the request level through reset so a level held across reset
      // does not count as a fresh edge.
      req_prev_q <= dbg_rd_req;
      armed_q    <= 1'b0;
      cpu_ce_q   <= 1'b0;
      mem_sel_q  <= MSEL_CPU;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b1;
      ticks_q    <= '0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      req_prev_q <= dbg_rd_req;
      armed_q    <= armed_d;
      cpu_ce_q   <= cpu_ce_d;
      mem_sel_q  <= mem_sel_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      ticks_q    <= ticks_d;
    end
  end

  assign cpu_ce       = cpu_ce_q;
  assign mem_sel      = mem_sel_q;
  assign mem_addr_dbg = addr_q;
  assign dbg_rd_data  = data_q;
  assign dbg_rd_valid = valid_q;
  assign halted       = halted_q;
  assign ce_ticks     = ticks_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned TICK_W  = 4;

  logic              clk;
  logic              rst;
  logic              run_sw;
  logic              step_pulse;
  logic              dbg_rd_req;
  logic [ADDR_W-1:0] dbg_rd_addr;
  logic [31:0]       mem_rdata;
  logic              cpu_ce;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr_dbg;
  logic [31:0]       dbg_rd_data;
  logic              dbg_rd_valid;
  logic              halted;
  logic [TICK_W-1:0] ce_ticks;

  int n_checks = 0;
  int n_err    = 0;

  cpu_run_ctrl #(
    .CLK_DIV (CLK_DIV),
    .ADDR_W  (ADDR_W),
    .TICK_W  (TICK_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run_sw       (run_sw),
    .step_pulse   (step_pulse),
    .dbg_rd_req   (dbg_rd_req),
    .dbg_rd_addr  (dbg_rd_addr),
    .mem_rdata    (mem_rdata),
    .cpu_ce       (cpu_ce),
    .mem_sel      (mem_sel),
    .mem_addr_dbg (mem_addr_dbg),
    .dbg_rd_data  (dbg_rd_data),
    .dbg_rd_valid (dbg_rd_valid),
    .halted       (halted),
    .ce_ticks     (ce_ticks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory contents seen by the debug reader.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 6'h05) return 32'hDEADBEEF;
    return {16'hC0DE, 10'h0, a};
  endfunction

  assign mem_rdata = mem_word(mem_addr_dbg);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 60) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: base mode (running or halted), an in-flight step,
  // a read in progress counted down over two cycles, and the prescaler
  // phase. Expected outputs describe the cycle following each clock edge.
  // ---------------------------------------------------------------------
  logic              model_live = 1'b0;
  logic              m_run, m_step, m_armed, m_prev;
  int                m_rd, m_phase;
  logic              e_ce, e_sel, e_valid, e_halted;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_data;
  logic [TICK_W-1:0] e_ticks;

  task automatic model_step();
    logic edge_now, take, fire, cap, at_end;
    if (rst) begin
      m_run = 0; m_step = 0; m_rd = 0; m_phase = 0; m_armed = 0;
      m_prev = dbg_rd_req;
      e_ce = 0; e_sel = 0; e_addr = '0; e_data = '0; e_valid = 0; e_halted = 1;
      e_ticks = '0;
    end else begin
      edge_now = dbg_rd_req && !m_prev;
      m_prev   = dbg_rd_req;
      take = 0; fire = 0; cap = 0;
      e_ticks = e_ticks + TICK_W'(e_ce);
      if (m_rd == 2) begin
        m_rd = 1; cap = 1; e_data = mem_word(e_addr);
      end else if (m_rd == 1) begin
        m_rd = 0;
      end else if (m_step) begin
        m_step = 0;
      end else if (m_run) begin
        at_end = (m_phase == int'(CLK_DIV) - 1);
        if (m_armed && (!at_end || !run_sw)) begin
          take = 1;
          if (run_sw && !at_end) m_phase++;
        end else if (!run_sw) begin
          m_run = 0;
        end else if (at_end) begin
          m_phase = 0; fire = 1;
        end else begin
          m_phase++;
        end
      end else begin
        if (m_armed) take = 1;
        else if (edge_now) take = 0;  // pending request blocks step and run
        else if (step_pulse) begin m_step = 1; fire = 1; end
        else if (run_sw) begin m_run = 1; m_phase = 0; end
      end
      if (take) begin
        m_rd = 2; e_addr = dbg_rd_addr;
      end
      m_armed  = (m_armed && !take) || edge_now;
      e_ce     = fire;
      e_sel    = (m_rd != 0);
      e_valid  = cap;
      e_halted = !m_run;
    end
    model_live = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("cpu_ce",       {31'b0, cpu_ce},       {31'b0, e_ce});
      chk("mem_sel",      {31'b0, mem_sel},      {31'b0, e_sel});
      chk("mem_addr_dbg", 32'(mem_addr_dbg),     32'(e_addr));
      chk("dbg_rd_data",  dbg_rd_data,           e_data);
      chk("dbg_rd_valid", {31'b0, dbg_rd_valid}, {31'b0, e_valid});
      chk("halted",       {31'b0, halted},       {31'b0, e_halted});
      chk("ce_ticks",     32'(ce_ticks),         32'(e_ticks));
      chk("ce_vs_sel",    {31'b0, cpu_ce & mem_sel}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ce(input int limit, output int k);
    k = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (cpu_ce) begin
        k = i;
        break;
      end
    end
  endtask

  int k, nce, nval, nsel, nunhalt, kv;
  logic [TICK_W-1:0] t0;
  logic [31:0] dval;

  initial begin
    rst = 1; run_sw = 1; step_pulse = 0; dbg_rd_req = 0; dbg_rd_addr = '0;

    // Reset then run.
    repeat (2) tick();
    chk("rst_ce", {31'b0, cpu_ce}, 32'd0);
    chk("rst_sel", {31'b0, mem_sel}, 32'd0);
    chk("rst_addr", 32'(mem_addr_dbg), 32'd0);
    chk("rst_data", dbg_rd_data, 32'd0);
    chk("rst_valid", {31'b0, dbg_rd_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd1);
    chk("rst_ticks", 32'(ce_ticks), 32'd0);
    tick();
    rst = 0;
    wait_ce(20, k);
    chk("first_ce_latency", k, 32'd5);
    wait_ce(20, k);
    chk("run_period", k, 32'd4);

    // Halt and step.
    run_sw = 0;
    repeat (3) tick();
    t0 = ce_ticks; nce = 0; nunhalt = 0;
    for (int p = 0; p < 3; p++) begin
      step_pulse = 1;
      tick();
      if (cpu_ce) nce++;
      if (!halted) nunhalt++;
      step_pulse = 0;
      for (int j = 0; j < 4; j++) begin
        tick();
        if (cpu_ce) nce++;
        if (!halted) nunhalt++;
      end
    end
    tick();
    chk("step_count", nce, 32'd3);
    chk("step_ticks", 32'(ce_ticks), 32'(t0 + TICK_W'(3)));
    chk("step_halted", nunhalt, 32'd0);

    // Debug read while halted; request held high afterwards.
    dbg_rd_addr = 6'h05; dbg_rd_req = 1;
    kv = 0; nsel = 0; nval = 0; dval = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (mem_sel) nsel++;
      if (dbg_rd_valid) begin
        nval++;
        if (kv == 0) begin kv = i; dval = dbg_rd_data; end
      end
    end
    chk("halt_rd_latency", kv, 32'd3);
    chk("halt_rd_sel_cycles", nsel, 32'd2);
    chk("halt_rd_count", nval, 32'd1);
    chk("halt_rd_data", dval, 32'hDEADBEEF);
    dbg_rd_req = 0;
    repeat (2) tick();

    // Step and request edge together: read wins, step dropped.
    t0 = ce_ticks; nce = 0; nval = 0;
    step_pulse = 1; dbg_rd_req = 1; dbg_rd_addr = 6'h2A;
    tick();
    step_pulse = 0;
    if (cpu_ce) nce++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ce) nce++;
      if (dbg_rd_valid) nval++;
    end
    chk("simul_ce", nce, 32'd0);
    chk("simul_rd", nval, 32'd1);
    chk("simul_ticks", 32'(ce_ticks), 32'(t0));
    chk("simul_data", dbg_rd_data, 32'hC0DE002A);
    dbg_rd_req = 0;
    repeat (2) tick();

    // Read in RUN one cycle before the enable slot: enable 2 cycles late.
    run_sw = 1;
    wait_ce(20, k);
    tick();
    dbg_rd_req = 1; dbg_rd_addr = 6'h07;
    wait_ce(20, k);
    chk("run_rd_ce_gap", k + 1, 32'd6);
    chk("run_rd_data", dbg_rd_data, 32'hC0DE0007);
    // Edge landing so the armed cycle is an enable slot: read deferred.
    dbg_rd_req = 0;
    repeat (2) tick();
    dbg_rd_req = 1; dbg_rd_addr = 6'h11;
    tick();
    tick();
    chk("defer_ce_kept", {31'b0, cpu_ce}, 32'd1);
    tick();
    chk("defer_sel", {31'b0, mem_sel}, 32'd1);
    chk("defer_no_valid_yet", {31'b0, dbg_rd_valid}, 32'd0);
    tick();
    chk("defer_valid", {31'b0, dbg_rd_valid}, 32'd1);
    chk("defer_data", dbg_rd_data, 32'hC0DE0011);
    dbg_rd_req = 0;

    // Reset asserted in RD_SETUP aborts the read.
    run_sw = 0;
    repeat (4) tick();
    dbg_rd_req = 1; dbg_rd_addr = 6'h03;
    tick();
    tick();
    chk("abort_in_setup", {31'b0, mem_sel}, 32'd1);
    rst = 1;
    tick();
    chk("abort_sel", {31'b0, mem_sel}, 32'd0);
    chk("abort_halted", {31'b0, halted}, 32'd1);
    nval = dbg_rd_valid ? 1 : 0;
    tick();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dbg_rd_valid) nval++;
    end
    chk("abort_no_valid", nval, 32'd0);
    dbg_rd_req = 0;

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(39) == 0) run_sw = ~run_sw;
      step_pulse = ($urandom_range(5) == 0);
      if ($urandom_range(4) == 0) dbg_rd_req = ~dbg_rd_req;
      dbg_rd_addr = ADDR_W'($urandom);
      rst = ($urandom_range(399) == 0);
    end
    rst = 0; step_pulse = 0; dbg_rd_req = 0;

    // ce_ticks wraps: 17 pulses on a 4-bit counter leaves 1.
    rst = 1; run_sw = 1;
    repeat (2) tick();
    rst = 0;
    nce = 0;
    for (int i = 0; i < 200 && nce < 17; i++) begin
      tick();
      if (cpu_ce) nce++;
    end
    tick();
    chk("wrap_pulses", nce, 32'd17);
    chk("wrap_ticks", 32'(ce_ticks), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
